// File: rtl/ising_axi_host_seq_pkg.sv
// Shared register map, state encodings and helpers for the Ising AXI host sequencer.
// Register addresses mirror the slave wrapper's map; keep the two in sync.
package ising_axi_host_seq_pkg;

   localparam logic [31:0] CTR_CUTOFF_ADDR = 32'h0000_1000;
   localparam logic [31:0] CTR_MAX_ADDR    = 32'h0000_1004;
   localparam logic [31:0] START_ADDR      = 32'h0000_1008;
   localparam logic [19:0] PHASE_ADDR_MASK = 20'h00002;

   localparam logic [3:0] ISEQ_IDLE      = 4'd0;
   localparam logic [3:0] ISEQ_LOAD_W    = 4'd1;
   localparam logic [3:0] ISEQ_WR_CUTOFF = 4'd2;
   localparam logic [3:0] ISEQ_WR_MAX    = 4'd3;
   localparam logic [3:0] ISEQ_WR_START  = 4'd4;
   localparam logic [3:0] ISEQ_WAIT      = 4'd5;
   localparam logic [3:0] ISEQ_READ      = 4'd6;
   localparam logic [3:0] ISEQ_PUSH      = 4'd7;
   localparam logic [3:0] ISEQ_DONE      = 4'd8;

   localparam logic [1:0] RDE_IDLE = 2'd0;
   localparam logic [1:0] RDE_REQ  = 2'd1;
   localparam logic [1:0] RDE_RESP = 2'd2;

   function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[32] ? 32'hFFFF_FFFF : s[31:0];
   endfunction

   function automatic logic [31:0] phase_addr(input logic [9:0] idx);
      return {PHASE_ADDR_MASK, idx, 2'b00};
   endfunction

endpackage

// File: rtl/ising_axi_rd_engine.sv
// Single-beat AXI-style read: one arvalid cycle, then rready until rvalid or timeout.
// Result is a one-cycle rd_valid pulse; rd_data holds until the next read completes.
module ising_axi_rd_engine
   import ising_axi_host_seq_pkg::*;
#(
   parameter int RD_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        axi_rst,
   input  logic        req,
   input  logic [31:0] addr,
   output logic        arvalid_q,
   output logic [31:0] araddr_q,
   output logic        rready,
   input  logic        rvalid,
   input  logic        rresp,
   input  logic [31:0] rdata,
   output logic        rd_valid,
   output logic        rd_err,
   output logic [31:0] rd_data
);

   localparam int TW = $clog2(RD_TIMEOUT) + 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(RD_TIMEOUT - 1);

   logic [1:0]    rd_state;
   logic [TW-1:0] tmo;

   always_ff @(posedge clk) begin
      if (axi_rst) begin
         rd_state  <= RDE_IDLE;
         arvalid_q <= 1'b0;
         araddr_q  <= '0;
         rready    <= 1'b0;
         rd_valid  <= 1'b0;
         rd_err    <= 1'b0;
         rd_data   <= '0;
         tmo       <= '0;
      end else begin
         rd_valid <= 1'b0;
         rd_err   <= 1'b0;
         case (rd_state)
            RDE_IDLE: begin
               if (req) begin
                  arvalid_q <= 1'b1;
                  araddr_q  <= addr;
                  rd_state  <= RDE_REQ;
               end
            end
            RDE_REQ: begin
               arvalid_q <= 1'b0;
               rready    <= 1'b1;
               tmo       <= '0;
               rd_state  <= RDE_RESP;
            end
            RDE_RESP: begin
               if (rvalid) begin
                  rd_data  <= rdata;
                  rd_err   <= rresp;
                  rd_valid <= 1'b1;
                  rready   <= 1'b0;
                  rd_state <= RDE_IDLE;
               end else if (tmo == TMO_LAST) begin
                  // Abandoned read still yields a (zero) word so the phase stream stays complete.
                  rd_data  <= '0;
                  rd_err   <= 1'b1;
                  rd_valid <= 1'b1;
                  rready   <= 1'b0;
                  rd_state <= RDE_IDLE;
               end else begin
                  tmo <= tmo + 1'b1;
               end
            end
            default: rd_state <= RDE_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/ising_axi_host_seq.sv
// Host-side sequencer for the Ising machine: weights in, counter regs, START,
// anneal wait, then phase-word readback onto a ready/valid stream.
module ising_axi_host_seq
   import ising_axi_host_seq_pkg::*;
#(
   parameter int N           = 3,
   parameter int PHASE_WORDS = 1,
   parameter int RD_TIMEOUT  = 64
) (
   input  logic        clk,
   input  logic        axi_rst,
   input  logic        run_start,
   input  logic [31:0] cfg_cutoff,
   input  logic [31:0] cfg_max,
   input  logic [31:0] cfg_rst_cycles,
   input  logic [31:0] cfg_wait_cycles,
   input  logic        w_valid,
   output logic        w_ready,
   input  logic        w_last,
   input  logic [31:0] w_addr,
   input  logic [31:0] w_data,
   output logic        ph_valid,
   input  logic        ph_ready,
   output logic [31:0] ph_data,
   output logic        ph_last,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic        wready,
   output logic [31:0] wr_addr,
   output logic [31:0] wdata,
   output logic        arvalid_q,
   output logic [31:0] araddr_q,
   output logic        rready,
   input  logic        rvalid,
   input  logic        rresp,
   input  logic [31:0] rdata
);

   // Never read fewer words than the spin count needs.
   localparam int MIN_WORDS = (N + 31) / 32;
   localparam int PW        = (PHASE_WORDS < MIN_WORDS) ? MIN_WORDS : PHASE_WORDS;
   localparam logic [9:0] LAST_IDX = 10'(PW - 1);

   logic [3:0]  state;
   logic [31:0] cut_q, max_q, rst_q, wait_q;
   logic [31:0] wait_cnt;
   logic [9:0]  idx;

   logic        rd_req;
   logic [31:0] rd_addr;
   logic        rd_valid, rd_err;
   logic [31:0] rd_data;

   // Read request is combinational so arvalid_q lands on the cycle after the decision.
   always_comb begin
      rd_req  = 1'b0;
      rd_addr = phase_addr(idx);
      if (state == ISEQ_WAIT && wait_cnt <= 32'd1) begin
         rd_req = 1'b1;
      end else if (state == ISEQ_PUSH && ph_ready && !ph_last) begin
         rd_req  = 1'b1;
         rd_addr = phase_addr(idx + 10'd1);
      end
   end

   ising_axi_rd_engine #(.RD_TIMEOUT(RD_TIMEOUT)) u_rd (
      .clk       (clk),
      .axi_rst   (axi_rst),
      .req       (rd_req),
      .addr      (rd_addr),
      .arvalid_q (arvalid_q),
      .araddr_q  (araddr_q),
      .rready    (rready),
      .rvalid    (rvalid),
      .rresp     (rresp),
      .rdata     (rdata),
      .rd_valid  (rd_valid),
      .rd_err    (rd_err),
      .rd_data   (rd_data)
   );

   always_ff @(posedge clk) begin
      if (axi_rst) begin
         state    <= ISEQ_IDLE;
         cut_q    <= '0;
         max_q    <= '0;
         rst_q    <= '0;
         wait_q   <= '0;
         wait_cnt <= '0;
         idx      <= '0;
         w_ready  <= 1'b0;
         ph_valid <= 1'b0;
         ph_data  <= '0;
         ph_last  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         wready   <= 1'b0;
         wr_addr  <= '0;
         wdata    <= '0;
      end else begin
         wready <= 1'b0;
         done   <= 1'b0;
         case (state)
            ISEQ_IDLE: begin
               if (run_start) begin
                  cut_q   <= cfg_cutoff;
                  max_q   <= cfg_max;
                  rst_q   <= cfg_rst_cycles;
                  wait_q  <= cfg_wait_cycles;
                  err     <= 1'b0;
                  idx     <= '0;
                  w_ready <= 1'b1;
                  busy    <= 1'b1;
                  state   <= ISEQ_LOAD_W;
               end
            end
            ISEQ_LOAD_W: begin
               if (w_valid) begin
                  wready  <= 1'b1;
                  wr_addr <= w_addr;
                  wdata   <= w_data;
                  if (w_last) begin
                     w_ready <= 1'b0;
                     state   <= ISEQ_WR_CUTOFF;
                  end
               end
            end
            ISEQ_WR_CUTOFF: begin
               wready  <= 1'b1;
               wr_addr <= CTR_CUTOFF_ADDR;
               wdata   <= cut_q;
               state   <= ISEQ_WR_MAX;
            end
            ISEQ_WR_MAX: begin
               wready  <= 1'b1;
               wr_addr <= CTR_MAX_ADDR;
               wdata   <= max_q;
               state   <= ISEQ_WR_START;
            end
            ISEQ_WR_START: begin
               wready   <= 1'b1;
               wr_addr  <= START_ADDR;
               wdata    <= rst_q;
               wait_cnt <= sat_add32(rst_q, wait_q);
               state    <= ISEQ_WAIT;
            end
            ISEQ_WAIT: begin
               // The START-write cycle counts as the first wait cycle; a zero sum still waits one.
               if (wait_cnt <= 32'd1) begin
                  wait_cnt <= '0;
                  state    <= ISEQ_READ;
               end else begin
                  wait_cnt <= wait_cnt - 32'd1;
               end
            end
            ISEQ_READ: begin
               if (rd_valid) begin
                  ph_valid <= 1'b1;
                  ph_data  <= rd_data;
                  ph_last  <= (idx == LAST_IDX);
                  err      <= err | rd_err;
                  state    <= ISEQ_PUSH;
               end
            end
            ISEQ_PUSH: begin
               if (ph_ready) begin
                  ph_valid <= 1'b0;
                  ph_last  <= 1'b0;
                  idx      <= idx + 10'd1;
                  if (ph_last) begin
                     done  <= 1'b1;
                     state <= ISEQ_DONE;
                  end else begin
                     state <= ISEQ_READ;
                  end
               end
            end
            ISEQ_DONE: begin
               busy  <= 1'b0;
               idx   <= '0;
               state <= ISEQ_IDLE;
            end
            default: state <= ISEQ_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ising_axi_host_seq.sv
// Directed bench for ising_axi_host_seq: full runs, back-pressure, read timeout,
// error response, ignored run_start while busy, and reset mid-run.
module tb_ising_axi_host_seq;
   import ising_axi_host_seq_pkg::*;

   logic        clk = 1'b0;
   logic        axi_rst = 1'b1;
   logic        run_start = 1'b0;
   logic [31:0] cfg_cutoff = '0, cfg_max = '0, cfg_rst_cycles = '0, cfg_wait_cycles = '0;
   logic        w_valid = 1'b0, w_last = 1'b0;
   logic [31:0] w_addr = '0, w_data = '0;
   logic        w_ready;
   logic        ph_valid, ph_last, ph_ready = 1'b0;
   logic [31:0] ph_data;
   logic        busy, done, err, wready, arvalid_q, rready;
   logic [31:0] wr_addr, wdata, araddr_q;
   logic        rvalid = 1'b0, rresp = 1'b0;
   logic [31:0] rdata = '0;

   ising_axi_host_seq #(.N(3), .PHASE_WORDS(1), .RD_TIMEOUT(64)) dut (
      .clk(clk), .axi_rst(axi_rst), .run_start(run_start),
      .cfg_cutoff(cfg_cutoff), .cfg_max(cfg_max),
      .cfg_rst_cycles(cfg_rst_cycles), .cfg_wait_cycles(cfg_wait_cycles),
      .w_valid(w_valid), .w_ready(w_ready), .w_last(w_last), .w_addr(w_addr), .w_data(w_data),
      .ph_valid(ph_valid), .ph_ready(ph_ready), .ph_data(ph_data), .ph_last(ph_last),
      .busy(busy), .done(done), .err(err),
      .wready(wready), .wr_addr(wr_addr), .wdata(wdata),
      .arvalid_q(arvalid_q), .araddr_q(araddr_q), .rready(rready),
      .rvalid(rvalid), .rresp(rresp), .rdata(rdata)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Bus monitor: sampled on the falling edge, away from the active edge.
   logic [31:0] wlog_a[$];
   logic [31:0] wlog_d[$];
   int cyc = 0, start_cyc = 0, ar_cyc = 0, ar_cnt = 0, rr_cnt = 0, ovl = 0;
   logic [31:0] ar_addr = '0;

   always @(negedge clk) begin
      cyc++;
      if (wready) begin
         wlog_a.push_back(wr_addr);
         wlog_d.push_back(wdata);
         if (wr_addr == START_ADDR) start_cyc = cyc;
      end
      if (arvalid_q) begin
         ar_cnt++;
         ar_cyc = cyc;
         ar_addr = araddr_q;
      end
      if (rready) rr_cnt++;
      if (wready && arvalid_q) ovl++;
   end

   // Slave read model: 0 = answer on 2nd rready cycle, 1 = never answer, 2 = answer with rresp=1.
   int slv_mode = 0;
   int slv_cnt = 0;
   logic [31:0] slv_data = '0;

   always @(negedge clk) begin
      if (rready && slv_mode != 1) begin
         if (slv_cnt == 1) begin
            rvalid = 1'b1;
            rresp  = (slv_mode == 2);
            rdata  = slv_data;
            slv_cnt = 0;
         end else begin
            rvalid = 1'b0;
            slv_cnt++;
         end
      end else begin
         rvalid = 1'b0;
         rresp  = 1'b0;
         slv_cnt = 0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_run(input logic [31:0] c, input logic [31:0] m,
                            input logic [31:0] r, input logic [31:0] w);
      cfg_cutoff = c; cfg_max = m; cfg_rst_cycles = r; cfg_wait_cycles = w;
      run_start = 1'b1;
      tick();
      run_start = 1'b0;
   endtask

   task automatic send_w(input logic [31:0] a, input logic [31:0] d, input logic last);
      w_valid = 1'b1; w_addr = a; w_data = d; w_last = last;
      tick();
      w_valid = 1'b0; w_last = 1'b0;
   endtask

   task automatic wait_ph(input string tag, input int lim);
      int n;
      n = 0;
      while (!ph_valid && n < lim) begin
         tick();
         n++;
      end
      chk(tag, 32'(ph_valid), 32'd1);
   endtask

   task automatic finish_run(input string tag);
      ph_ready = 1'b1;
      tick();
      ph_ready = 1'b0;
      chk({tag, "_done"}, 32'(done), 32'd1);
      tick();
      chk({tag, "_done_once"}, 32'(done), 32'd0);
      chk({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_ctl"}, 32'({w_ready, ph_valid, ph_last, busy, done, err, wready, arvalid_q, rready}), 32'd0);
      chk({tag, "_bus"}, wr_addr | wdata | araddr_q | ph_data, 32'd0);
   endtask

   initial begin
      int b, ar0, rr0;
      logic stable;
      logic [31:0] d0;

      repeat (3) tick();
      chk_reset("reset");
      axi_rst = 1'b0;
      tick();

      // Run 1: three weights, normal read of 0x5.
      slv_mode = 0; slv_data = 32'h5;
      b = wlog_a.size();
      start_run(32'd10, 32'd20, 32'd4, 32'd2);
      chk("r1_busy", 32'(busy), 32'd1);
      chk("r1_w_ready", 32'(w_ready), 32'd1);
      send_w(32'h0100_0000, 32'd5, 1'b0);
      send_w(32'h0100_0004, 32'd7, 1'b0);
      send_w(32'h0100_0008, 32'd1, 1'b1);
      wait_ph("r1_ph_valid", 200);
      chk("r1_nwrites", 32'(wlog_a.size() - b), 32'd6);
      chk("r1_wa0", wlog_a[b],   32'h0100_0000); chk("r1_wd0", wlog_d[b],   32'd5);
      chk("r1_wa1", wlog_a[b+1], 32'h0100_0004); chk("r1_wd1", wlog_d[b+1], 32'd7);
      chk("r1_wa2", wlog_a[b+2], 32'h0100_0008); chk("r1_wd2", wlog_d[b+2], 32'd1);
      chk("r1_cut_a", wlog_a[b+3], CTR_CUTOFF_ADDR); chk("r1_cut_d", wlog_d[b+3], 32'd10);
      chk("r1_max_a", wlog_a[b+4], CTR_MAX_ADDR);    chk("r1_max_d", wlog_d[b+4], 32'd20);
      chk("r1_st_a",  wlog_a[b+5], START_ADDR);      chk("r1_st_d",  wlog_d[b+5], 32'd4);
      chk("r1_ar_lat", 32'(ar_cyc - start_cyc), 32'd6);
      chk("r1_araddr", ar_addr, 32'h0000_2000);
      chk("r1_ph_data", ph_data, 32'h5);
      chk("r1_ph_last", 32'(ph_last), 32'd1);
      chk("r1_err", 32'(err), 32'd0);

      // Back-pressure: ph_ready low for 10 cycles.
      ar0 = ar_cnt;
      d0 = ph_data;
      stable = 1'b1;
      repeat (10) begin
         tick();
         if (!(ph_valid === 1'b1 && ph_data === d0 && ph_last === 1'b1)) stable = 1'b0;
      end
      chk("r1_hold_stable", 32'(stable), 32'd1);
      chk("r1_no_new_ar", 32'(ar_cnt - ar0), 32'd0);
      finish_run("r1");

      // Run 2: slave never answers -> timeout after 64 rready cycles.
      slv_mode = 1;
      rr0 = rr_cnt;
      start_run(32'd1, 32'd2, 32'd0, 32'd0);
      send_w(32'h0100_0000, 32'd3, 1'b1);
      wait_ph("r2_ph_valid", 300);
      chk("r2_tmo_cycles", 32'(rr_cnt - rr0), 32'd64);
      chk("r2_err", 32'(err), 32'd1);
      chk("r2_ph_data", ph_data, 32'h0);
      finish_run("r2");
      chk("r2_err_sticky", 32'(err), 32'd1);

      // Run 3: err cleared on start, run_start while busy ignored, rresp=1 read.
      slv_mode = 2; slv_data = 32'hA5;
      b = wlog_a.size();
      start_run(32'h33, 32'h44, 32'd1, 32'd1);
      chk("r3_err_clr", 32'(err), 32'd0);
      cfg_cutoff = 32'h99; cfg_max = 32'h88; cfg_rst_cycles = 32'h77;
      run_start = 1'b1;
      send_w(32'h0100_0010, 32'd9, 1'b1);
      run_start = 1'b0;
      wait_ph("r3_ph_valid", 200);
      chk("r3_cut_d", wlog_d[b+1], 32'h33);
      chk("r3_max_d", wlog_d[b+2], 32'h44);
      chk("r3_st_d",  wlog_d[b+3], 32'd1);
      chk("r3_err", 32'(err), 32'd1);
      chk("r3_ph_data", ph_data, 32'hA5);
      finish_run("r3");
      tick();
      chk("r3_ignored_start", 32'(busy), 32'd0);

      // Run 4: reset asserted during WAIT, then a clean run.
      slv_mode = 0; slv_data = 32'h3;
      ar0 = ar_cnt;
      start_run(32'd5, 32'd6, 32'd20, 32'd20);
      send_w(32'h0100_0000, 32'd2, 1'b1);
      repeat (6) tick();
      chk("r4_in_wait", 32'({busy, wready, arvalid_q}), 32'b100);
      axi_rst = 1'b1;
      tick();
      chk_reset("r4_midrst");
      axi_rst = 1'b0;
      tick();
      chk("r4_no_read", 32'(ar_cnt - ar0), 32'd0);
      start_run(32'd5, 32'd6, 32'd0, 32'd3);
      send_w(32'h0100_0000, 32'd2, 1'b1);
      wait_ph("r4_ph_valid", 200);
      chk("r4_ph_data", ph_data, 32'h3);
      chk("r4_err", 32'(err), 32'd0);
      finish_run("r4");

      chk("no_wr_rd_overlap", 32'(ovl), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ising_axi_host_seq.md
Name: ising_axi_host_seq

Overview:
- AXI initiator that drives the Ising machine's AXI-style register/weight port: streams weights in, programs the counter registers, pulses START, waits for the anneal, then reads back the phase words.
- Sits between a host-side command/stream source (DMA or testbench) and the Ising AXI slave wrapper.
- Removes per-register sequencing from software and makes full runs repeatable in simulation and on FPGA.

Parameters:
- N, 3, number of spins; used only to size the phase readback.
- PHASE_WORDS, 1, number of 32-bit phase words read per run; must be at least ceil(N/32).
- RD_TIMEOUT, 64, cycles allowed in RD_RESP for rvalid before a read is abandoned.

Ports:
- clk  in  1  system clock.
- axi_rst  in  1  synchronous, active-high reset.
- run_start  in  1  one-cycle start request; honoured only in IDLE.
- cfg_cutoff  in  32  value written to `CTR_CUTOFF_ADDR.
- cfg_max  in  32  value written to `CTR_MAX_ADDR.
- cfg_rst_cycles  in  32  value written to `START_ADDR (run-window length).
- cfg_wait_cycles  in  32  extra settle cycles after the run window.
- w_valid  in  1  weight beat valid.
- w_ready  out  1  weight beat accepted.
- w_last  in  1  final weight beat.
- w_addr  in  32  weight register address; forwarded unchanged.
- w_data  in  32  weight value.
- ph_valid  out  1  phase word valid.
- ph_ready  in  1  phase word accepted.
- ph_data  out  32  phase word.
- ph_last  out  1  marks the last phase word.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at the end of a run.
- err  out  1  sticky read error; cleared by an accepted run_start or by reset.
- wready  out  1  write strobe to the slave (single-cycle, no response).
- wr_addr  out  32  write address.
- wdata  out  32  write data.
- arvalid_q  out  1  read request.
- araddr_q  out  32  read address.
- rready  out  1  read data accept.
- rvalid  in  1  read data valid.
- rresp  in  1  read response; 1 = error.
- rdata  in  32  read data.

Behaviour:
- Reset, applied at any point including mid-run: every output 0, state IDLE, all counters and captured config cleared.
- All outputs are registered.
- The block never asserts wready and arvalid_q in the same cycle.
- State IDLE:
  - run_start captures all cfg_* inputs, clears err, and moves to LOAD_W.
  - run_start while busy is ignored.
- State LOAD_W:
  - w_ready = 1.
  - Each cycle with w_valid=1, the next cycle drives wready=1, wr_addr=w_addr, wdata=w_data, so one write issues per accepted beat.
  - A beat with w_last=1 moves to WR_CUTOFF after its write issues.
  - w_valid=0 inserts idle cycles with wready=0.
  - Zero weights are not supported; w_last is required on the final beat.
- State WR_CUTOFF: one cycle, wready=1, wr_addr=`CTR_CUTOFF_ADDR, wdata=cfg_cutoff.
- State WR_MAX: one cycle, same form with `CTR_MAX_ADDR and cfg_max.
- State WR_START: one cycle, same form with `START_ADDR and cfg_rst_cycles.
- State WAIT:
  - Down-counter loaded with the 33-bit sum cfg_rst_cycles + cfg_wait_cycles, saturated to 32'hFFFFFFFF.
  - Moves to RD_REQ when the counter reaches 0; a sum of 0 means one cycle in WAIT.
- State RD_REQ:
  - One cycle with arvalid_q=1.
  - araddr_q = {`PHASE_ADDR_MASK, idx[9:0], 2'b00}, where idx is the current phase word, 0..PHASE_WORDS-1.
- State RD_RESP:
  - arvalid_q=0, rready=1, araddr_q held.
  - On rvalid=1: capture rdata; if rresp=1 set err; go to PUSH. rready drops the following cycle.
  - If RD_TIMEOUT cycles pass without rvalid: set err, capture 32'h0, go to PUSH.
- State PUSH:
  - ph_valid=1, ph_data = captured word, ph_last = (idx == PHASE_WORDS-1).
  - ph_valid, ph_data and ph_last stay stable until ph_ready.
  - On ph_ready: increment idx; go to RD_REQ, or to DONE after the last word.
- State DONE: done=1 for one cycle, then IDLE.
- A stale rvalid seen in IDLE/LOAD_W/WAIT is ignored; rready stays 0 in those states.

Decomposition:
- Shared defines.vh: `CTR_CUTOFF_ADDR, `CTR_MAX_ADDR, `START_ADDR, `PHASE_ADDR_MASK, plus new state encodings (localparams ISEQ_*).
- One natural sub-module: ising_axi_rd_engine.
  - Contains RD_REQ/RD_RESP, the timeout counter and the capture register.
  - Handshake: req/addr in; data/err/valid out.

Test Plan:
- Reset, then run_start with 3 weights (0x01000000→5, 0x01000004→7, last 0x01000008→1), cutoff=10, max=20, rst=4, wait=2 -> exactly 3 weight writes, then cutoff/max/start writes in order with matching wdata; arvalid_q asserted exactly 6 cycles after the START write.
- Slave model returns rdata=0x5 for the phase read with PHASE_WORDS=1 -> ph_data=0x5, ph_last=1, done pulses 1 cycle after ph_ready, busy=0 after.
- ph_ready held low 10 cycles -> ph_valid/ph_data stable all 10 cycles; no new arvalid_q issued.
- Slave never asserts rvalid -> after 64 cycles err=1 and ph_data=0; the next accepted run_start clears err.
- rresp=1 on read -> err=1 and data still delivered; run_start pulsed while busy -> ignored, captured config unchanged.
- axi_rst asserted during WAIT -> next cycle all outputs 0, state IDLE; a fresh run then completes normally.
